// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - op field layout, size codes, FSM encodings and access checks
package load_store_unit_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Misaligned halfword/word or illegal size: answered without touching memory
  function automatic logic access_err(input logic [3:0] op, input logic [1:0] addr_lo);
    logic e;
    case (op[OP_SZ_HI:OP_SZ_LO])
      SIZE_B:   e = 1'b0;
      SIZE_H:   e = addr_lo[0];
      SIZE_W:   e = (addr_lo != 2'b00);
      SIZE_ILL: e = 1'b1;
      default:  e = 1'b1;
    endcase
    access_err = e;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and BRAM port bundle
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       load_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_err, load_data,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_err, load_data,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane write mask, store replication and load extraction
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_dout,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    mask  = 4'b0000;
    din   = wdata;
    rdata = mem_dout;
    b     = mem_dout[{addr_lo, 3'b000} +: 8];
    h     = addr_lo[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (op[OP_SZ_HI:OP_SZ_LO])
      SIZE_B: begin
        mask  = 4'b0001 << addr_lo;
        din   = {4{wdata[7:0]}};
        rdata = op[OP_UNS] ? {24'd0, b} : {{24{b[7]}}, b};
      end
      SIZE_H: begin
        mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        din   = {2{wdata[15:0]}};
        rdata = op[OP_UNS] ? {16'd0, h} : {{16{h[15]}}, h};
      end
      SIZE_W: begin
        mask  = 4'b1111;
        din   = wdata;
        rdata = mem_dout;
      end
      default: mask = 4'b0000;
    endcase
    we = op[OP_STORE] ? mask : 4'b0000;
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer in front of a word-wide BRAM
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       load_q;
  logic [3:0]        lane_we;
  logic [31:0]       lane_din;
  logic [31:0]       lane_rdata;

  lsu_lane_align u_align (
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (wdata_q),
    .mem_dout (bus.mem_dout),
    .we       (lane_we),
    .din      (lane_din),
    .rdata    (lane_rdata)
  );

  // Memory strobes decode from state so an asynchronous reset clears them at once
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_err   = (state == ST_RESP) && err_q;
  assign bus.load_data  = load_q;
  assign bus.mem_en     = (state == ST_ACCESS) || (state == ST_WAIT);
  assign bus.mem_we     = (state == ST_ACCESS) ? lane_we : 4'b0000;
  assign bus.mem_din    = (state == ST_ACCESS && op_q[OP_STORE]) ? lane_din : 32'd0;
  assign bus.mem_addr   = {2'b00, addr_q[ADDR_W-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      load_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= access_err(bus.req_op, bus.req_addr[1:0]);
            state   <= access_err(bus.req_op, bus.req_addr[1:0]) ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (op_q[OP_STORE]) begin
            state <= ST_RESP;
          end else begin
            cnt   <= 2'(RD_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            load_q <= lane_rdata;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed checks of load_store_unit at RD_LAT 1 and 3
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus1 ();
  load_store_unit_if #(.ADDR_W(32)) bus3 ();

  load_store_unit #(.ADDR_W(32), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  load_store_unit #(.ADDR_W(32), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        v1 = 1'b0;
  logic        v3 = 1'b0;
  logic        cur = 1'b0;

  assign bus1.req_valid = v1;
  assign bus1.req_op    = req_op;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus3.req_valid = v3;
  assign bus3.req_op    = req_op;
  assign bus3.req_addr  = req_addr;
  assign bus3.req_wdata = req_wdata;

  // BRAM models: read-first, word-indexed, dout RD_LAT edges after the enabled edge
  logic [31:0] m1 [16];
  logic [31:0] m3 [16];
  logic [31:0] p1 = 32'd0;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      for (int k = 0; k < 4; k++)
        if (bus1.mem_we[k]) m1[bus1.mem_addr[3:0]][8*k +: 8] <= bus1.mem_din[8*k +: 8];
      p1 <= m1[bus1.mem_addr[3:0]];
    end
  end
  assign bus1.mem_dout = p1;

  always @(posedge clk) begin
    if (bus3.mem_en) begin
      for (int k = 0; k < 4; k++)
        if (bus3.mem_we[k]) m3[bus3.mem_addr[3:0]][8*k +: 8] <= bus3.mem_din[8*k +: 8];
      p3[0] <= m3[bus3.mem_addr[3:0]];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.mem_dout = p3[2];

  wire        ready_m = cur ? bus3.req_ready  : bus1.req_ready;
  wire        en_m    = cur ? bus3.mem_en     : bus1.mem_en;
  wire [3:0]  we_m    = cur ? bus3.mem_we     : bus1.mem_we;
  wire [31:0] din_m   = cur ? bus3.mem_din    : bus1.mem_din;
  wire [31:0] addr_m  = cur ? bus3.mem_addr   : bus1.mem_addr;
  wire        rv_m    = cur ? bus3.resp_valid : bus1.resp_valid;
  wire        err_m   = cur ? bus3.resp_err   : bus1.resp_err;
  wire [31:0] ld_m    = cur ? bus3.load_data  : bus1.load_data;

  int errors = 0;
  int checks = 0;
  int lat, en_cnt;
  logic [3:0]  we_or;
  logic [31:0] din_s, addr_s, ld_s;
  logic        err_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; records latency, strobe activity and the response seen in RESP
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    check("ready_idle", 32'(ready_m), 32'd1);
    req_op = op; req_addr = addr; req_wdata = wd;
    v1 = !cur; v3 = cur;
    lat = -1; en_cnt = 0; we_or = 4'd0; din_s = 32'd0; addr_s = 32'd0; ld_s = 32'd0; err_s = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      v1 = 1'b0; v3 = 1'b0;
      if (en_m) begin en_cnt++; addr_s = addr_m; end
      if (we_m != 4'd0) begin we_or |= we_m; din_s = din_m; end
      if (rv_m) begin lat = c; err_s = err_m; ld_s = ld_m; break; end
    end
  endtask

  task automatic load_chk(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] exp, input int exp_lat);
    run_op(op, addr, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, ld_s, exp);
    check({tag, "_err"}, 32'(err_s), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] keep);
    run_op(op, addr, 32'hFFFF_FFFF);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err"}, 32'(err_s), 32'd1);
    check({tag, "_en"}, 32'(en_cnt), 32'd0);
    check({tag, "_we"}, 32'(we_or), 32'd0);
    check({tag, "_keep"}, ld_s, keep);
  endtask

  initial begin
    int rv_cnt;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus1.req_ready), 32'd1);
    check("rst_rv", 32'(bus1.resp_valid), 32'd0);
    check("rst_err", 32'(bus1.resp_err), 32'd0);
    check("rst_ld", bus1.load_data, 32'd0);
    check("rst_en", 32'(bus1.mem_en), 32'd0);
    check("rst_we", 32'(bus1.mem_we), 32'd0);
    check("rst_addr", bus1.mem_addr, 32'd0);
    check("rst_din", bus1.mem_din, 32'd0);
    rst_n = 1'b1;

    run_op(4'b1010, 32'h0, 32'h36);
    check("sw0_lat", 32'(lat), 32'd2);
    check("sw0_err", 32'(err_s), 32'd0);
    check("sw0_en", 32'(en_cnt), 32'd1);
    check("sw0_we", 32'(we_or), 32'hF);
    check("sw0_addr", addr_s, 32'd0);
    check("sw0_din", din_s, 32'h36);

    run_op(4'b1010, 32'h8, 32'h80FF7F01);
    check("sw8_lat", 32'(lat), 32'd2);
    load_chk("lb9", 4'b0000, 32'h9, 32'h0000007F, 3);
    check("lb9_we", 32'(we_or), 32'd0);
    load_chk("lbu9", 4'b0100, 32'h9, 32'h0000007F, 3);
    load_chk("lhA", 4'b0001, 32'hA, 32'hFFFF80FF, 3);
    load_chk("lhuA", 4'b0101, 32'hA, 32'h000080FF, 3);
    load_chk("lbB", 4'b0000, 32'hB, 32'hFFFFFF80, 3);
    load_chk("lbuB", 4'b0100, 32'hB, 32'h00000080, 3);
    load_chk("lh8", 4'b0001, 32'h8, 32'h00007F01, 3);

    run_op(4'b1010, 32'h4, 32'h11223344);
    run_op(4'b1000, 32'h7, 32'h000000AB);
    check("sb7_we", 32'(we_or), 32'h8);
    check("sb7_din", din_s, 32'hABABABAB);
    check("sb7_addr", addr_s, 32'h1);
    check("sb7_lat", 32'(lat), 32'd2);
    load_chk("lw4", 4'b0010, 32'h4, 32'hAB223344, 3);

    err_chk("lh3", 4'b0001, 32'h3, 32'hAB223344);
    err_chk("lw6", 4'b0010, 32'h6, 32'hAB223344);
    err_chk("ill", 4'b0011, 32'h0, 32'hAB223344);

    run_op(4'b1101, 32'h6, 32'h1234ABCD);
    check("sh6_we", 32'(we_or), 32'hC);
    check("sh6_din", din_s, 32'hABCDABCD);
    load_chk("lw4b", 4'b0110, 32'h4, 32'hABCD3344, 3);

    cur = 1'b1;
    run_op(4'b1010, 32'h10, 32'hDEADBEEF);
    check("l3_sw_lat", 32'(lat), 32'd2);
    load_chk("l3_lw", 4'b0010, 32'h10, 32'hDEADBEEF, 5);
    check("l3_en", 32'(en_cnt), 32'd4);

    // Abort a load in WAIT with an asynchronous reset
    @(negedge clk);
    req_op = 4'b0010; req_addr = 32'h10; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_en", 32'(bus3.mem_en), 32'd0);
    check("abort_ready", 32'(bus3.req_ready), 32'd1);
    check("abort_ld", bus3.load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus3.resp_valid) rv_cnt++;
    end
    check("abort_no_resp", 32'(rv_cnt), 32'd0);
    load_chk("l3_after", 4'b0010, 32'h10, 32'hDEADBEEF, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the processor datapath (ALU address / register-file store data) and the word-wide datamemory block RAM.
- Translates byte, halfword and word load/store requests into BRAM enable, byte-write-enable, word address and lane-replicated write data.
- Waits out the BRAM read latency, then returns the aligned, sign- or zero-extended load result over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of the processor byte address and of mem_addr.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1..3.

Ports:
- clk  in  1  single clock; feeds the BRAM clka as well.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on a rising edge where req_valid && req_ready.
- req_op  in  4  {is_store, is_unsigned, size[1:0]}; size 00=byte, 01=half, 10=word, 11=illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; set for misaligned access or illegal size.
- load_data  out  32  load result; holds its value until the next successful load.
- mem_en  out  1  to BRAM ena.
- mem_we  out  4  to BRAM wea; bit k enables bits [8k+7:8k].
- mem_addr  out  ADDR_W  word address, equal to {2'b00, addr[ADDR_W-1:2]}.
- mem_din  out  32  to BRAM dina.
- mem_dout  in  32  from BRAM douta.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, load_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- States are IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept, register op, addr and wdata.
  - If size==11, or half with addr[0]=1, or word with addr[1:0]!=0, go to RESP with err=1. No memory access is made in this case.
  - Otherwise go to ACCESS.
- ACCESS:
  - Exactly one cycle; mem_en=1 and mem_addr valid.
  - Store: mem_we and mem_din are driven for this cycle; the write commits on the closing edge; next state is RESP.
  - Load: mem_we=0; next state is WAIT.
- WAIT:
  - Lasts RD_LAT cycles, counted with a 2-bit counter.
  - mem_en stays 1 and mem_addr is held.
  - On the last WAIT edge, mem_dout is extracted into load_data; next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err is valid; next state is IDLE.
  - req_ready=0 in this cycle, so there are no back-to-back accepts.
- Latency, counting the accept edge as 0:
  - store: resp_valid high in cycle 2.
  - load: resp_valid high in cycle RD_LAT+2.
  - error: resp_valid high in cycle 1.
- req_ready=0 in ACCESS, WAIT and RESP. req_* inputs are ignored then.
- Store lanes (little-endian; lane k = addr[1:0]):
  - SB: mem_din={4{b}}, mem_we=4'b0001<<addr[1:0].
  - SH: mem_din={2{h}}, mem_we = addr[1] ? 4'b1100 : 4'b0011.
  - SW: mem_din=wdata, mem_we=4'b1111.
- Load extract:
  - byte = mem_dout[8k+7:8k]; half = addr[1] ? [31:16] : [15:0].
  - Sign-extend when is_unsigned=0, zero-extend otherwise. Word loads ignore is_unsigned.
- Store with is_unsigned=1 behaves identically to is_unsigned=0.
- Error response leaves load_data unchanged.
- Reset mid-operation: outputs return to reset values at once and the FSM goes to IDLE.
  - A store in ACCESS at the moment of reset is not guaranteed to have written.
  - No response is issued for an aborted request.
- mem_we is never nonzero outside ACCESS; mem_en is never 1 in IDLE or RESP.

Decomposition:
- Shared include lsu_defs.vh holds:
  - op field positions;
  - SIZE_B/SIZE_H/SIZE_W/SIZE_ILL codes;
  - state encodings ST_IDLE/ST_ACCESS/ST_WAIT/ST_RESP.
- One combinational sub-module, lsu_lane_align:
  - inputs op, addr[1:0], wdata, mem_dout;
  - outputs we mask, replicated din, extended load value.
- load_store_unit keeps the FSM, latency counter and registers.

Test Plan:
- Reset then SW addr=0x0, wdata=0x36:
  - one ACCESS cycle with mem_we=1111, mem_addr=0, mem_din=0x36;
  - resp_valid in cycle 2, resp_err=0.
- After SW 0x8 wdata=0x80FF7F01, run LB/LBU at 0x9 and LH/LHU at 0xA (RD_LAT=1):
  - LB 0x9 -> load_data=0x0000007F; LBU 0x9 -> 0x0000007F;
  - LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF;
  - each resp_valid at cycle 3.
- SB 0x7 data=0xAB over word 0x4 holding 0x11223344:
  - mem_we=1000, mem_din=0xABABABAB;
  - then LW 0x4 -> 0xAB223344.
- LH at 0x3, LW at 0x6, and op size=11:
  - each gives resp_err=1 at cycle 1;
  - mem_en and mem_we stay 0;
  - load_data retains its previous value.
- RD_LAT=3 build, LW at 0x10 holding 0xDEADBEEF:
  - mem_en high for 4 cycles;
  - resp_valid at cycle 5 with 0xDEADBEEF.
- Assert rst_n low during the WAIT of a load:
  - mem_en=0 and req_ready=1 immediately;
  - no resp_valid follows;
  - a subsequent LW completes normally.
